vga_timing_controller: RTL and testbench

Sequences the 640x480@60 Hz VGA raster from the 100 MHz system clock. Owns the pixel-rate enable, the horizontal (0..799) and vertical (0..524) counters, and the registered hsync/vsync/active decode. Provides frame-boundary start/stop control, pixel coordinates and line/frame strobes to the pixel generator downstream.

---
 rtl/vga_timing_controller_if.sv | 32 +++
 rtl/vga_timing_controller.sv | 155 +++++++++++++++
 tb/tb_vga_timing_controller.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_controller_if.sv
// rtl/vga_timing_controller_if.sv - raster timing bundle between the VGA timing controller and the pixel generator
// Ports (master = timing controller, slave = pixel generator):
//   enable       slave->master  request video output, honoured at frame boundaries
//   pixel_tick   master->slave  one-clk pulse every CLK_DIV clocks
//   x, y         master->slave  current pixel column / line
//   hsync, vsync master->slave  active-low sync pulses
//   active       master->slave  visible-area flag
//   line_start   master->slave  one-clk pulse when x is loaded with 0
//   frame_start  master->slave  one-clk pulse when (x,y) is loaded with (0,0)
//   running      master->slave  controller is in RUN or DRAIN
interface vga_timing_controller_if;
    logic       enable;
    logic       pixel_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic       running;

    modport master (
        input  enable,
        output pixel_tick, x, y, hsync, vsync, active, line_start, frame_start, running
    );

    modport slave (
        output enable,
        input  pixel_tick, x, y, hsync, vsync, active, line_start, frame_start, running
    );
endinterface

// File: rtl/vga_timing_controller.sv
// rtl/vga_timing_controller.sv - 640x480@60 VGA raster sequencer with frame-boundary start/stop
// Ports:
//   clk    system clock, all logic on rising edge
//   rst_n  asynchronous active-low reset
//   vga    timing bundle (master side): enable in; pixel_tick, x, y, hsync, vsync,
//          active, line_start, frame_start, running out
module vga_timing_controller #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                          clk,
    input  logic                          rst_n,
    vga_timing_controller_if.master       vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic          tick;
    logic          wrap_line;
    logic          wrap_frame;
    logic [9:0]    x_nxt;
    logic [9:0]    y_nxt;

    // Free-running divider and the raster position one tick ahead.
    always_comb begin
        tick       = (div_q == DIV_LAST);
        div_d      = tick ? '0 : div_q + 1'b1;
        wrap_line  = (x_q == H_LAST);
        wrap_frame = wrap_line && (y_q == V_LAST);
        x_nxt      = wrap_line ? 10'd0 : x_q + 10'd1;
        y_nxt      = y_q;
        if (wrap_line) begin
            y_nxt = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
    end

    // Next state and registered outputs. All decode is taken from the values
    // being loaded (x_d/y_d) so sync, active and strobes line up with x/y.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (tick) begin
            case (state_q)
                ST_IDLE:  if (vga.enable) state_d = ST_RUN;
                ST_RUN:   if (!vga.enable) state_d = ST_DRAIN;
                ST_DRAIN: begin
                    if (vga.enable) begin
                        state_d = ST_RUN;
                    end else if (wrap_frame) begin
                        state_d = ST_IDLE;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase

            if (state_d == ST_IDLE) begin
                // Parked: blanked, syncs deasserted, no strobes on the stop wrap.
                x_d      = 10'd0;
                y_d      = 10'd0;
                hsync_d  = 1'b1;
                vsync_d  = 1'b1;
                active_d = 1'b0;
            end else begin
                if (state_q == ST_IDLE) begin
                    // Start edge keeps (0,0) so pixel 0 gets a full tick period.
                    x_d = 10'd0;
                    y_d = 10'd0;
                end else begin
                    x_d = x_nxt;
                    y_d = y_nxt;
                end
                hsync_d       = !((x_d >= HS_BEG) && (x_d < HS_END));
                vsync_d       = !((y_d >= VS_BEG) && (y_d < VS_END));
                active_d      = (x_d < H_ACT) && (y_d < V_ACT);
                line_start_d  = (x_d == 10'd0);
                frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_tick  = tick;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.active      = active_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.running     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_vga_timing_controller.sv
// tb/tb_vga_timing_controller.sv - directed bench for vga_timing_controller on a shrunken 16x12 raster
module tb_vga_timing_controller;
    localparam int CLK_DIV   = 4;
    localparam int H_ACTIVE  = 8;
    localparam int H_FP      = 2;
    localparam int H_SYNC    = 3;
    localparam int H_BP      = 3;
    localparam int V_ACTIVE  = 6;
    localparam int V_FP      = 2;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 2;
    // 16 pixels x 12 lines; hsync low x=10..12, vsync low y=8..9
    localparam int FRAME_CLK = 16 * 12 * CLK_DIV;   // 768
    localparam int LINE_CLK  = 16 * CLK_DIV;        // 64

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vga_timing_controller_if vif();

    vga_timing_controller #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vga  (vif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_x"},           int'(vif.x), 0);
        check({pfx, "_y"},           int'(vif.y), 0);
        check({pfx, "_hsync"},       int'(vif.hsync), 1);
        check({pfx, "_vsync"},       int'(vif.vsync), 1);
        check({pfx, "_active"},      int'(vif.active), 0);
        check({pfx, "_pixel_tick"},  int'(vif.pixel_tick), 0);
        check({pfx, "_line_start"},  int'(vif.line_start), 0);
        check({pfx, "_frame_start"}, int'(vif.frame_start), 0);
        check({pfx, "_running"},     int'(vif.running), 0);
    endtask

    initial begin
        int n, first, ticks;
        int act_cnt, hs_cnt, hs_line0, vs_cnt, ls_cnt, ls_first, fs_at, bad;
        int fs_cnt, idle_cnt, px, py;
        logic exp_h, exp_v, exp_a;

        vif.enable = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // Release with enable low: divider free-runs, raster parked.
        rst_n = 1'b1;
        first = -1;
        ticks = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (vif.pixel_tick) begin
                ticks++;
                if (first < 0) first = i;
            end
        end
        check("first_tick_edge", first, CLK_DIV - 1);
        check("ticks_in_20clk", ticks, 5);
        check("idle_x", int'(vif.x), 0);
        check("idle_y", int'(vif.y), 0);
        check("idle_running", int'(vif.running), 0);

        // Start: divider is 0 here, so frame_start lands on the 4th edge.
        vif.enable = 1'b1;
        n = 0;
        while (!vif.frame_start && n < 2 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("start_latency", n, CLK_DIV);
        check("start_frame_start", int'(vif.frame_start), 1);
        check("start_line_start", int'(vif.line_start), 1);
        check("start_running", int'(vif.running), 1);
        check("start_active", int'(vif.active), 1);
        check("start_x", int'(vif.x), 0);
        check("start_y", int'(vif.y), 0);
        repeat (3) @(negedge clk);
        check("x_held_3clk", int'(vif.x), 0);
        @(negedge clk);
        check("x_after_4clk", int'(vif.x), 1);
        check("frame_start_1clk", int'(vif.frame_start), 0);

        // Full-frame scan from the next frame_start.
        n = 0;
        while (!vif.frame_start && n < FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        check("second_frame_seen", int'(vif.frame_start), 1);
        act_cnt = 0; hs_cnt = 0; hs_line0 = 0; vs_cnt = 0;
        ls_cnt = 0; ls_first = 0; fs_at = 0; bad = 0;
        for (int i = 1; i <= FRAME_CLK; i++) begin
            @(negedge clk);
            if (vif.active) act_cnt++;
            if (!vif.hsync) begin
                hs_cnt++;
                if (vif.y == 10'd0) hs_line0++;
            end
            if (!vif.vsync) vs_cnt++;
            if (vif.line_start) begin
                ls_cnt++;
                if (ls_first == 0) ls_first = i;
            end
            if (vif.frame_start && fs_at == 0) fs_at = i;
            exp_h = !(vif.x >= 10'd10 && vif.x < 10'd13);
            exp_v = !(vif.y >= 10'd8 && vif.y < 10'd10);
            exp_a = (vif.x < 10'd8) && (vif.y < 10'd6);
            if (vif.hsync != exp_h || vif.vsync != exp_v || vif.active != exp_a) bad++;
        end
        check("active_clk_per_frame", act_cnt, 8 * 6 * CLK_DIV);
        check("hsync_low_clk_line0", hs_line0, H_SYNC * CLK_DIV);
        check("hsync_low_clk_frame", hs_cnt, 12 * H_SYNC * CLK_DIV);
        check("vsync_low_clk_frame", vs_cnt, V_SYNC * LINE_CLK);
        check("line_starts_per_frame", ls_cnt, 12);
        check("line_start_spacing", ls_first, LINE_CLK);
        check("frame_start_spacing", fs_at, FRAME_CLK);
        check("decode_vs_xy_errors", bad, 0);

        // Stop: drop enable at y=2; frame completes, parks at the wrap.
        n = 0;
        while (vif.y != 10'd2 && n < FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        vif.enable = 1'b0;
        n = 0; fs_cnt = 0; px = 0; py = 0;
        while (vif.running && n < 2 * FRAME_CLK) begin
            px = int'(vif.x);
            py = int'(vif.y);
            @(negedge clk);
            n++;
            if (vif.frame_start) fs_cnt++;
        end
        check("stop_running", int'(vif.running), 0);
        check("stop_within_frame", int'(n <= FRAME_CLK), 1);
        check("stop_last_x", px, 15);
        check("stop_last_y", py, 11);
        check("stop_no_frame_start", fs_cnt, 0);
        check("stop_x", int'(vif.x), 0);
        check("stop_y", int'(vif.y), 0);
        check("stop_active", int'(vif.active), 0);
        check("stop_hsync", int'(vif.hsync), 1);
        check("stop_vsync", int'(vif.vsync), 1);
        repeat (2 * LINE_CLK) @(negedge clk);
        check("stays_idle", int'(vif.running), 0);

        // Resume: drop at y=2, re-raise at y=4 -> no gap at the wrap.
        vif.enable = 1'b1;
        n = 0;
        while (!vif.frame_start && n < 2 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("restart_frame_start", int'(vif.frame_start), 1);
        n = 0;
        while (vif.y != 10'd2 && n < FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        vif.enable = 1'b0;
        n = 0;
        while (vif.y != 10'd4 && n < FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        check("drain_reached_y4", int'(vif.y), 4);
        vif.enable = 1'b1;
        n = 0; idle_cnt = 0;
        while (!vif.frame_start && n < FRAME_CLK) begin
            @(negedge clk);
            n++;
            if (!vif.running) idle_cnt++;
        end
        check("resume_frame_start", int'(vif.frame_start), 1);
        check("resume_no_idle_gap", idle_cnt, 0);
        check("resume_x", int'(vif.x), 0);
        check("resume_y", int'(vif.y), 0);

        // Reset mid-frame at (11,8): hsync and vsync both low there.
        n = 0;
        while (!(vif.x == 10'd11 && vif.y == 10'd8) && n < FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        check("midframe_hsync_low", int'(vif.hsync), 0);
        check("midframe_vsync_low", int'(vif.vsync), 0);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!vif.frame_start && n < 2 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("post_reset_start_latency", n, CLK_DIV);
        check("post_reset_x", int'(vif.x), 0);
        check("post_reset_y", int'(vif.y), 0);
        check("post_reset_running", int'(vif.running), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
